// File: rtl/seq_pkg.sv
// Shared types and constants for the step sequencer (step_scheduler and tempo_divider).
package seq_pkg;

  localparam int unsigned NOTE_W          = 3;
  localparam int unsigned MIN_STEP_CYCLES = 2;

  typedef logic [NOTE_W-1:0] note_t;

  localparam note_t NOTE_REST = '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } seq_state_t;

endpackage

// File: rtl/step_scheduler_if.sv
// Control, pattern-write and playback bundle of step_scheduler.
// SWING_EN adds the swing_cycles control input.
interface step_scheduler_if
  import seq_pkg::*;
#(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned DIV_W  = 24
);

  logic              start;
  logic              pause;
  logic              stop;
  logic [DIV_W-1:0]  step_cycles;
  logic [DIV_W-1:0]  gate_cycles;
`ifdef SWING_EN
  logic [DIV_W-1:0]  swing_cycles;
`endif
  logic              wr_valid;
  logic              wr_ready;
  logic [STEP_W-1:0] wr_step;
  note_t             wr_note;
  note_t             note;
  logic              gate;
  logic [STEP_W-1:0] beat_count;
  logic              step_strobe;
  logic              running;

  modport master (
`ifdef SWING_EN
    output swing_cycles,
`endif
    output start, pause, stop, step_cycles, gate_cycles,
    output wr_valid, wr_step, wr_note,
    input  wr_ready, note, gate, beat_count, step_strobe, running
  );

  modport slave (
`ifdef SWING_EN
    input  swing_cycles,
`endif
    input  start, pause, stop, step_cycles, gate_cycles,
    input  wr_valid, wr_step, wr_note,
    output wr_ready, note, gate, beat_count, step_strobe, running
  );

endinterface

// File: rtl/tempo_divider.sv
// Step-length down-counter: clamps the tempo, flags the last (pattern-read) cycle of a step
// and registers the step strobe. SWING_EN lengthens even steps and shortens odd ones.
module tempo_divider
  import seq_pkg::*;
#(
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             tick,
  input  logic [DIV_W-1:0] step_cycles,
`ifdef SWING_EN
  input  logic [DIV_W-1:0] swing_cycles,
  input  logic             odd_step,
`endif
  output logic             pre_strobe_c,
  output logic [DIV_W:0]   step_len_c,
  output logic             strobe
);

  logic [DIV_W:0]   count;
  logic [DIV_W-1:0] base_c;
`ifdef SWING_EN
  logic [DIV_W-1:0] half_c;
  logic [DIV_W-1:0] swing_c;
`endif

  // Length of the step about to be loaded, with the minimum-tempo clamp applied.
  always_comb begin
    base_c = (step_cycles < DIV_W'(MIN_STEP_CYCLES)) ? DIV_W'(MIN_STEP_CYCLES) : step_cycles;
`ifdef SWING_EN
    half_c     = base_c >> 1;
    swing_c    = (swing_cycles > half_c) ? half_c : swing_cycles;
    step_len_c = odd_step ? ({1'b0, base_c} - {1'b0, swing_c})
                          : ({1'b0, base_c} + {1'b0, swing_c});
`else
    step_len_c = {1'b0, base_c};
`endif
  end

  assign pre_strobe_c = (count == '0);

  // count holds the cycles left after the current one; tick low freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= load;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= step_len_c - (DIV_W+1)'(1);
      end else if (tick) begin
        count <= count - (DIV_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Tempo-driven step sequencer: pattern RAM, run/pause/stop FSM, gate window and write port.
// SWING_EN enables swing timing through the swing_cycles input.
module step_scheduler
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 16,
  parameter int unsigned DIV_W     = 24
) (
  input logic           clk,
  input logic           rst_n,
  step_scheduler_if.slave bus
);

  localparam int unsigned STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  seq_state_t        state;
  note_t             pattern [NUM_STEPS];
  logic [STEP_W-1:0] beat_count;
  note_t             note;
  logic              gate;
  logic              running;
  logic [DIV_W:0]    gate_left;
  logic              strobe;

  logic              go_c;
  logic              end_c;
  logic              adv_c;
  logic              load_c;
  logic              tick_c;
  logic              in_range_c;
  logic              wr_en_c;
  logic              pre_strobe_c;
  logic [STEP_W-1:0] next_beat_c;
  note_t             rd_note_c;
  logic [DIV_W:0]    step_len_c;
  logic [DIV_W:0]    gate_len_c;

  // Out-of-range write addresses only exist when NUM_STEPS is not a power of two.
  if ((1 << STEP_W) == NUM_STEPS) begin : g_full_range
    assign in_range_c = 1'b1;
  end else begin : g_part_range
    assign in_range_c = (32'(bus.wr_step) < NUM_STEPS);
  end

  // Step sequencing decisions; the RAM is read only on start and on the last cycle of a step.
  always_comb begin
    go_c        = (state == IDLE) && bus.start && !bus.stop;
    end_c       = (state == RUN) && pre_strobe_c;
    adv_c       = end_c && !bus.stop && !bus.pause;
    load_c      = go_c || adv_c;
    tick_c      = (state == RUN) && !bus.stop && !bus.pause && !pre_strobe_c;
    next_beat_c = (go_c || (beat_count == LAST_STEP)) ? '0 : beat_count + STEP_W'(1);
    rd_note_c   = pattern[next_beat_c];
    gate_len_c  = ({1'b0, bus.gate_cycles} < step_len_c) ? {1'b0, bus.gate_cycles} : step_len_c;
    wr_en_c     = bus.wr_valid && !(go_c || end_c) && in_range_c;
  end

  tempo_divider #(
    .DIV_W(DIV_W)
  ) u_tempo (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (bus.stop),
    .load         (load_c),
    .tick         (tick_c),
    .step_cycles  (bus.step_cycles),
`ifdef SWING_EN
    .swing_cycles (bus.swing_cycles),
    .odd_step     (next_beat_c[0]),
`endif
    .pre_strobe_c (pre_strobe_c),
    .step_len_c   (step_len_c),
    .strobe       (strobe)
  );

  // FSM, pattern RAM and gate window; state changes override the step-load updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_count <= '0;
      note       <= NOTE_REST;
      gate       <= 1'b0;
      running    <= 1'b0;
      gate_left  <= '0;
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
        pattern[i] <= NOTE_REST;
      end
    end else begin
      if (wr_en_c) begin
        pattern[bus.wr_step] <= bus.wr_note;
      end

      if (load_c) begin
        beat_count <= next_beat_c;
        note       <= rd_note_c;
        if ((rd_note_c != NOTE_REST) && (gate_len_c != '0)) begin
          gate      <= 1'b1;
          gate_left <= gate_len_c - (DIV_W+1)'(1);
        end else begin
          gate      <= 1'b0;
          gate_left <= '0;
        end
      end else if (state == RUN) begin
        if (gate_left != '0) begin
          gate_left <= gate_left - (DIV_W+1)'(1);
        end else begin
          gate <= 1'b0;
        end
      end

      if (bus.stop) begin
        state      <= IDLE;
        beat_count <= '0;
        note       <= NOTE_REST;
        gate       <= 1'b0;
        gate_left  <= '0;
        running    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            // Pausing kills the gate for the rest of this step.
            if (bus.pause) begin
              state     <= PAUSE;
              running   <= 1'b0;
              gate      <= 1'b0;
              gate_left <= '0;
            end
          end
          PAUSE: begin
            if (bus.start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.wr_ready    = !(go_c || end_c);
  assign bus.note        = note;
  assign bus.gate        = gate;
  assign bus.beat_count  = beat_count;
  assign bus.step_strobe = strobe;
  assign bus.running     = running;

endmodule

// File: tb/tb_step_scheduler.sv
// Randomized scoreboard bench for step_scheduler (NUM_STEPS=4, DIV_W=8); SWING_EN adds swing runs.
module tb_step_scheduler;
  import seq_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned DW = 8;

  typedef struct packed {
    note_t         note;
    logic          gate;
    logic [SW-1:0] beat;
    logic          strobe;
    logic          running;
    logic          ready;
  } obs_t;

  typedef struct packed {
    logic [SW-1:0] beat;
    note_t         note;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  step_scheduler_if #(.STEP_W(SW), .DIV_W(DW)) bus ();

  step_scheduler #(.NUM_STEPS(N), .DIV_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t exp_q[$];
  ev_t  ev_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Stimulus values applied on the next cycle.
  bit s_rst, s_start, s_pause, s_stop, s_wv;
  int s_sc, s_gc, s_ws, s_wn;
`ifdef SWING_EN
  int s_sw;
`endif

  // Reference model: mode 0 idle, 1 run, 2 pause; m_el counts cycles elapsed in the step.
  int m_mode, m_step, m_note, m_el, m_len, m_glen;
  bit m_killed, m_strobe;
  int pat[N];

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_note = 0; m_el = 0; m_len = 2; m_glen = 0;
    m_killed = 0; m_strobe = 0;
    for (int i = 0; i < N; i++) pat[i] = 0;
  endtask

  task automatic begin_step(input int b);
    int s, sw;
    ev_t ev;
    s  = (s_sc < 2) ? 2 : s_sc;
    sw = 0;
`ifdef SWING_EN
    sw = (s_sw > s / 2) ? s / 2 : s_sw;
`endif
    m_len    = (b % 2 == 0) ? s + sw : s - sw;
    m_glen   = (s_gc < m_len) ? s_gc : m_len;
    m_step   = b;
    m_note   = pat[b];
    m_el     = 0;
    m_killed = 0;
    m_strobe = 1;
    ev.beat  = SW'(b);
    ev.note  = note_t'(pat[b]);
    ev_q.push_back(ev);
  endtask

  // One clock: apply stimulus, queue this cycle's expected outputs, advance the model.
  task automatic cycle();
    obs_t e;
    bit   rd;
    @(negedge clk);
    rst_n           = s_rst;
    bus.start       = s_start;
    bus.pause       = s_pause;
    bus.stop        = s_stop;
    bus.step_cycles = DW'(s_sc);
    bus.gate_cycles = DW'(s_gc);
`ifdef SWING_EN
    bus.swing_cycles = DW'(s_sw);
`endif
    bus.wr_valid    = s_wv;
    bus.wr_step     = SW'(s_ws);
    bus.wr_note     = note_t'(s_wn);
    if (!s_rst) begin
      model_reset();
      ev_q.delete();
    end
    rd        = (m_mode == 0 && s_start && !s_stop) || (m_mode == 1 && m_el == m_len - 1);
    e.note    = note_t'(m_note);
    e.gate    = (m_mode == 1) && !m_killed && (m_note != 0) && (m_el < m_glen);
    e.beat    = SW'(m_step);
    e.strobe  = m_strobe;
    e.running = (m_mode == 1);
    e.ready   = !rd;
    exp_q.push_back(e);
    if (s_rst) begin
      m_strobe = 0;
      if (s_stop) begin
        m_mode = 0; m_step = 0; m_note = 0; m_el = 0;
      end else begin
        case (m_mode)
          0: if (s_start) begin m_mode = 1; begin_step(0); end
          1: begin
            if (s_pause) begin
              m_mode = 2; m_killed = 1;
            end else if (m_el == m_len - 1) begin
              begin_step((m_step + 1) % N);
            end else begin
              m_el++;
            end
          end
          default: if (s_start) m_mode = 1;
        endcase
      end
      if (s_wv && !rd) pat[s_ws] = s_wn;
    end
  endtask

  task automatic write_pattern(input int p0, input int p1, input int p2, input int p3);
    int p[N];
    p = '{p0, p1, p2, p3};
    for (int i = 0; i < N; i++) begin
      s_wv = 1; s_ws = i; s_wn = p[i];
      cycle();
    end
    s_wv = 0;
  endtask

  task automatic start_run(input int cycles);
    s_start = 1; cycle(); s_start = 0;
    repeat (cycles) cycle();
  endtask

  task automatic stop_now();
    s_stop = 1; cycle(); s_stop = 0;
  endtask

  // Monitor: every cycle pops the expected outputs; every strobe pops the expected step event.
  initial begin
    obs_t e, got;
    ev_t  ev;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e           = exp_q.pop_front();
        got.note    = bus.note;
        got.gate    = bus.gate;
        got.beat    = bus.beat_count;
        got.strobe  = bus.step_strobe;
        got.running = bus.running;
        got.ready   = bus.wr_ready;
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got note=%0d gate=%0b beat=%0d strobe=%0b run=%0b rdy=%0b, want note=%0d gate=%0b beat=%0d strobe=%0b run=%0b rdy=%0b",
                   $time, got.note, got.gate, got.beat, got.strobe, got.running, got.ready,
                   e.note, e.gate, e.beat, e.strobe, e.running, e.ready);
        end
        if (bus.step_strobe === 1'b1) begin
          vectors++;
          if (ev_q.size() == 0) begin
            miscompares++;
            $display("FAIL strobe_event @%0t: got strobe beat=%0d note=%0d, want no strobe",
                     $time, bus.beat_count, bus.note);
          end else begin
            ev = ev_q.pop_front();
            if (bus.beat_count !== ev.beat || bus.note !== ev.note) begin
              miscompares++;
              $display("FAIL strobe_event @%0t: got beat=%0d note=%0d, want beat=%0d note=%0d",
                       $time, bus.beat_count, bus.note, ev.beat, ev.note);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    s_rst = 0; s_start = 0; s_pause = 0; s_stop = 0; s_wv = 0;
    s_sc = 4; s_gc = 2; s_ws = 0; s_wn = 0;
`ifdef SWING_EN
    s_sw = 0;
`endif
    model_reset();
    repeat (3) cycle();
    s_rst = 1;
    cycle();

    // Basic play: pattern {1,0,5,7}, S=4, gate 2.
    write_pattern(1, 0, 5, 7);
    s_sc = 4; s_gc = 2;
    start_run(20);

    // Pause partway into step 2, hold 10 cycles, resume.
    for (int k = 0; k < 40 && !(m_mode == 1 && m_step == 2 && m_el == 1); k++) cycle();
    s_pause = 1; cycle(); s_pause = 0;
    repeat (10) cycle();
    start_run(12);

    // Writes held during play, including the current step.
    s_wv = 1;
    repeat (40) begin
      s_ws = $urandom_range(0, N - 1);
      s_wn = $urandom_range(0, 7);
      cycle();
    end
    s_wv = 0;

    // stop+pause+start together, then clamped 2-cycle steps.
    s_stop = 1; s_pause = 1; s_start = 1; cycle();
    s_stop = 0; s_pause = 0; s_start = 0;
    repeat (2) cycle();
    s_sc = 0; s_gc = 1;
    start_run(12);

    // Legato: gate longer than the step.
    stop_now();
    write_pattern(3, 3, 0, 3);
    s_sc = 4; s_gc = 8;
    start_run(20);

`ifdef SWING_EN
    s_sw = 1; s_gc = 3;
    repeat (20) cycle();
    s_sw = 3;
    repeat (20) cycle();
    s_sw = 0;
`endif

    // Random control, tempo and write traffic.
    repeat (600) begin
      s_start = ($urandom_range(0, 19) == 0);
      s_pause = ($urandom_range(0, 29) == 0);
      s_stop  = ($urandom_range(0, 59) == 0);
      s_wv    = ($urandom_range(0, 1) == 1);
      s_ws    = $urandom_range(0, N - 1);
      s_wn    = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) s_sc = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) s_gc = $urandom_range(0, 9);
`ifdef SWING_EN
      if ($urandom_range(0, 15) == 0) s_sw = $urandom_range(0, 4);
`endif
      cycle();
    end
    s_start = 0; s_pause = 0; s_stop = 0; s_wv = 0;

    // Asynchronous reset mid-step, then play the cleared pattern.
    stop_now();
    write_pattern(2, 4, 6, 1);
    s_sc = 5; s_gc = 3;
    start_run(7);
    s_rst = 0;
    repeat (2) cycle();
    s_rst = 1;
    cycle();
    start_run(12);

    stop_now();
    repeat (3) cycle();
    repeat (2) @(negedge clk);
    #3;
    vectors++;
    if (ev_q.size() != 0) begin
      miscompares++;
      $display("FAIL strobe_drain: got %0d unseen strobes, want 0", ev_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
